counter_int_ctrl: RTL and testbench



---
 rtl/counter_int_ctrl.sv | 114 +++++++++++
 tb/tb_counter_int_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_int_ctrl.sv
// Interrupt aggregation: resynchronises raw counter interrupts, keeps sticky
// software-clearable status, masks it and coalesces events into one level IRQ.
module counter_int_ctrl #(
  parameter int COUNTER_NUM = 4
) (
  input  logic                       i_pclk,
  input  logic                       i_prst_n,
  input  logic [COUNTER_NUM*8-1:0]   i_int_raw,
  input  logic [COUNTER_NUM*8-1:0]   i_int_mask,
  input  logic [COUNTER_NUM*8-1:0]   i_int_clr,
  input  logic [COUNTER_NUM*8-1:0]   i_int_set,
  input  logic [3:0]                 i_coal_thresh,
  input  logic [15:0]                i_coal_timeout,
  output logic [COUNTER_NUM*8-1:0]   o_int_status,
  output logic [COUNTER_NUM*8-1:0]   o_int_masked,
  output logic [3:0]                 o_event_cnt,
  output logic                       o_irq
);
  localparam int N = COUNTER_NUM * 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] FIRE  = 2'd2;

  logic [N-1:0] r_s1, r_s2, r_s3, r_status, r_masked_d;
  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [15:0]  r_timer;
  logic         r_irq;

  logic [N-1:0] w_rise, w_masked;
  logic         w_ev, w_any;
  logic [1:0]   w_state_n;
  logic [3:0]   w_cnt_n, w_cnt_inc;
  logic [15:0]  w_timer_n;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_masked  = r_status & i_int_mask;
  assign w_any     = |w_masked;
  // Any bit newly visible (fresh status or freshly unmasked) is one event.
  assign w_ev      = |(w_masked & ~r_masked_d);
  assign w_cnt_inc = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_timer_n = r_timer;
    case (r_state)
      IDLE: begin
        w_cnt_n   = 4'd0;
        w_timer_n = 16'd0;
        if (w_ev) begin
          w_cnt_n   = 4'd1;
          w_state_n = (i_coal_thresh <= 4'd1) ? FIRE : ACCUM;
        end
      end
      ACCUM: begin
        w_timer_n = r_timer + 16'd1;
        if (w_ev) w_cnt_n = w_cnt_inc;
        // Cancel wins over any fire condition.
        if (!w_any) begin
          w_state_n = IDLE;
          w_cnt_n   = 4'd0;
          w_timer_n = 16'd0;
        end else if ((w_cnt_n >= i_coal_thresh) ||
                     ((i_coal_timeout != 16'd0) && (w_timer_n == i_coal_timeout))) begin
          w_state_n = FIRE;
        end
      end
      FIRE: begin
        w_timer_n = 16'd0;
        if (w_ev) w_cnt_n = w_cnt_inc;
        if (!w_any) begin
          w_state_n = IDLE;
          w_cnt_n   = 4'd0;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = 4'd0;
        w_timer_n = 16'd0;
      end
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!i_prst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_status   <= '0;
      r_masked_d <= '0;
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_timer    <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      r_s1       <= i_int_raw;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_status   <= (r_status & ~i_int_clr) | w_rise | i_int_set;
      r_masked_d <= w_masked;
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_timer    <= w_timer_n;
      r_irq      <= (w_state_n == FIRE);
    end
  end

  assign o_int_status = r_status;
  assign o_int_masked = w_masked;
  assign o_event_cnt  = r_cnt;
  assign o_irq        = r_irq;
endmodule

// File: tb/tb_counter_int_ctrl.sv
// Scoreboard bench for counter_int_ctrl: expectations are queued as stimulus
// is applied and popped/compared one cycle later.
module tb_counter_int_ctrl;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  raw, mask, clr, set;
  logic [3:0]    thresh;
  logic [15:0]   tmo;
  logic [N-1:0]  status, masked;
  logic [3:0]    cnt;
  logic          irq;

  typedef struct {
    string        nm;
    logic [N-1:0] care;
    logic [N-1:0] st;
    logic         irq;
    logic [3:0]   cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  counter_int_ctrl #(.COUNTER_NUM(4)) dut (
    .i_pclk(clk), .i_prst_n(rst_n), .i_int_raw(raw), .i_int_mask(mask),
    .i_int_clr(clr), .i_int_set(set), .i_coal_thresh(thresh),
    .i_coal_timeout(tmo), .o_int_status(status), .o_int_masked(masked),
    .o_event_cnt(cnt), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [N+4:0] got(input logic [N-1:0] care);
    return {status & care, irq, cnt};
  endfunction

  function automatic logic [N+4:0] want(input exp_t x);
    return {x.st & x.care, x.irq, x.cnt};
  endfunction

  function automatic exp_t mk(input string nm, input logic [N-1:0] care,
                              input logic [N-1:0] st, input logic ir, input logic [3:0] c);
    exp_t x;
    x.nm = nm; x.care = care; x.st = st; x.irq = ir; x.cnt = c;
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 0; raw = '1; mask = '1; clr = '0; set = '1; thresh = 0; tmo = 0;
    sb.push_back(mk("reset", '1, '0, 1'b0, 4'd0));
    ticks(3);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e) || masked !== '0) begin
      n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt);
    end
    raw = '0; set = '0; mask = '0;
    tick();
    rst_n = 1;
    ticks(4);
  endtask

  task automatic test_event_path();
    mask = 32'h20; thresh = 0; tmo = 0;
    raw[5] = 1'b1;
    sb.push_back(mk("path_e2", '1, '0, 1'b0, 4'd0));
    sb.push_back(mk("path_e3", '1, 32'h20, 1'b0, 4'd0));
    sb.push_back(mk("path_e4", '1, 32'h20, 1'b1, 4'd1));
    ticks(2);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); n_chk++;
      if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    end
    clr[5] = 1'b1;
    sb.push_back(mk("path_clr", '1, '0, 1'b1, 4'd1));
    sb.push_back(mk("path_drop", '1, '0, 1'b0, 4'd0));
    tick(); clr = '0;
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    tick();
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    raw[5] = 1'b0; mask = '0;
    ticks(4);
  endtask

  task automatic test_set_clr();
    raw[2] = 1'b1;
    ticks(3);
    clr[2] = 1'b1; set[2] = 1'b1;
    sb.push_back(mk("setclr_both", 32'h4, 32'h4, 1'b0, 4'd0));
    tick(); clr = '0; set = '0;
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    clr[2] = 1'b1;
    sb.push_back(mk("setclr_clr", 32'h4, '0, 1'b0, 4'd0));
    sb.push_back(mk("setclr_hold", 32'h4, '0, 1'b0, 4'd0));
    tick(); clr = '0;
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    ticks(5);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    raw[2] = 1'b0;
    ticks(3);
  endtask

  task automatic test_threshold();
    mask = 32'h700; thresh = 3; tmo = 0;
    for (int k = 0; k < 3; k++) begin
      raw[8+k] = 1'b1;
      sb.push_back(mk($sformatf("thr_pre%0d", k), 32'h700, 32'h700 >> (2 - k) & 32'h700, 1'b0, 4'(k)));
      sb.push_back(mk($sformatf("thr_ev%0d", k), 32'h700, 32'h700 >> (2 - k) & 32'h700, k == 2, 4'(k + 1)));
      ticks(3);
      e = sb.pop_front(); n_chk++;
      if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
      tick();
      e = sb.pop_front(); n_chk++;
      if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
      if (k < 2) ticks(6);
    end
    clr = '1; tick(); clr = '0; tick();
    raw = '0; mask = '0;
    ticks(4);
  endtask

  task automatic test_timeout();
    mask = 32'h1000; thresh = 8; tmo = 20;
    raw[12] = 1'b1;
    sb.push_back(mk("tmo_entry", '1, 32'h1000, 1'b0, 4'd1));
    sb.push_back(mk("tmo_19", '1, 32'h1000, 1'b0, 4'd1));
    sb.push_back(mk("tmo_20", '1, 32'h1000, 1'b1, 4'd1));
    ticks(4);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    ticks(19);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    tick();
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    clr = '1; tick(); clr = '0; tick();
    raw = '0; mask = '0; tmo = 0;
    ticks(4);
  endtask

  task automatic test_mask();
    mask = '0; thresh = 1;
    raw[0] = 1'b1;
    sb.push_back(mk("mask_off", 32'h1, 32'h1, 1'b0, 4'd0));
    ticks(6);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    mask[0] = 1'b1;
    sb.push_back(mk("mask_on", 32'h1, 32'h1, 1'b1, 4'd1));
    tick();
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    mask[0] = 1'b0;
    sb.push_back(mk("mask_drop", 32'h1, 32'h1, 1'b0, 4'd0));
    tick();
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    raw = '0; clr = '1; tick(); clr = '0;
    ticks(4);
  endtask

  task automatic test_cancel();
    mask = '1; thresh = 4; tmo = 0;
    set[16] = 1'b1; tick(); set = '0; tick();
    ticks(3);
    set[17] = 1'b1; tick(); set = '0;
    sb.push_back(mk("cancel_cnt2", 32'h30000, 32'h30000, 1'b0, 4'd2));
    tick();
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    clr = '1;
    sb.push_back(mk("cancel_idle", '1, '0, 1'b0, 4'd0));
    tick(); clr = '0; ticks(3);
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
  endtask

  task automatic test_saturate();
    mask = '1; thresh = 15; tmo = 0;
    for (int k = 0; k < 17; k++) begin
      set[k] = 1'b1; tick(); set = '0; tick();
      if (k == 13) begin
        sb.push_back(mk("sat_14", 32'h3fff, 32'h3fff, 1'b0, 4'd14));
        e = sb.pop_front(); n_chk++;
        if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
      end
    end
    sb.push_back(mk("sat_17", 32'h1ffff, 32'h1ffff, 1'b1, 4'd15));
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
    rst_n = 0;
    sb.push_back(mk("reset_in_fire", '1, '0, 1'b0, 4'd0));
    tick(); rst_n = 1;
    e = sb.pop_front(); n_chk++;
    if (got(e.care) !== want(e)) begin n_fail++; $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d", e.nm, status, irq, cnt, e.st, e.irq, e.cnt); end
  endtask

  initial begin
    test_reset();
    test_event_path();
    test_set_clr();
    test_threshold();
    test_timeout();
    test_mask();
    test_cancel();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
